// File: rtl/line_buf_pkg.sv
// line_buf_pkg
//   Shared types and width helpers for the cascaded line-buffer address
//   generator.
//   - line_buf_state_e : frame FSM states (IDLE, PRELOAD, DRAIN, RUN)
//   - cnt_w()          : counter width for a modulus n, never below 1 bit
//   - col_w()          : per-buffer column counter width
//   - beat_w()         : frame beat counter width
//   - drain_w()        : drain wait counter width
package line_buf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRELOAD = 2'd1,
        DRAIN   = 2'd2,
        RUN     = 2'd3
    } line_buf_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int col_w(input int img_w);
        return cnt_w(img_w);
    endfunction

    function automatic int beat_w(input int img_w, input int img_h);
        return cnt_w(img_w * img_h);
    endfunction

    function automatic int drain_w(input int uram_lat, input int bram_lat,
                                   input int num_lines);
        return cnt_w(uram_lat + (num_lines - 1) * bram_lat);
    endfunction

endpackage

// File: rtl/en_delay_line.sv
// en_delay_line
//   Single-bit shift register of DEPTH stages with asynchronous reset.
//   Ports:
//     clk - clock
//     rst - asynchronous, active-high reset (clears every stage)
//     d   - bit entering the first stage
//     q   - bit leaving the last stage, DEPTH cycles after d
module en_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sr <= '0;
                else     sr <= d;
            end
        end else begin : g_many
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sr <= '0;
                else     sr <= {sr[DEPTH-2:0], d};
            end
        end
    endgenerate

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/line_buf_addr_gen.sv
// line_buf_addr_gen
//   Address / enable generator for a URAM -> BRAM0 -> ... -> BRAM(N-1)
//   cascaded row buffer. Preloads NUM_LINES rows from URAM, waits for the
//   cascade to drain, then emits one URAM beat per (delayed) step until the
//   frame's last beat, where it pulses frame_done and returns to IDLE.
//   Ports:
//     clk, rst      - clock, asynchronous active-high reset
//     start         - one-cycle pulse, begins a frame (IDLE only)
//     step          - advance one column (RUN only)
//     uram_rd_addr  - URAM read address, ADDR_STRIDE per beat
//     uram_rd_en    - URAM read enable
//     bram_addr     - buffer i address at slice i
//     bram_en       - buffer i read/write enable (read-first)
//     init_done     - preload finished and cascade drained
//     frame_done    - one-cycle pulse after the frame's last beat
//   Input protocol: start and step are single-cycle qualifiers with no
//   back-pressure; a step seen outside RUN and a start seen outside IDLE
//   are dropped, never queued.
module line_buf_addr_gen
    import line_buf_pkg::*;
#(
    parameter int IMG_W       = 4,
    parameter int IMG_H       = 8,
    parameter int NUM_LINES   = 3,
    parameter int ADDR_STRIDE = 16,
    parameter int URAM_A_W    = 23,
    parameter int BRAM_A_W    = 14,
    parameter int URAM_LAT    = 3,
    parameter int BRAM_LAT    = 2,
    parameter int STEP_REG    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          step,
    output logic [URAM_A_W-1:0]           uram_rd_addr,
    output logic                          uram_rd_en,
    output logic [NUM_LINES*BRAM_A_W-1:0] bram_addr,
    output logic [NUM_LINES-1:0]          bram_en,
    output logic                          init_done,
    output logic                          frame_done
);

    localparam int COL_W     = col_w(IMG_W);
    localparam int BEAT_W    = beat_w(IMG_W, IMG_H);
    localparam int DRAIN_W   = drain_w(URAM_LAT, BRAM_LAT, NUM_LINES);
    localparam int DRAIN_CYC = URAM_LAT + (NUM_LINES - 1) * BRAM_LAT;

    localparam logic [BEAT_W-1:0]   PRE_LAST    = BEAT_W'(NUM_LINES * IMG_W - 1);
    localparam logic [BEAT_W-1:0]   FRAME_LAST  = BEAT_W'(IMG_W * IMG_H - 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST  = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [COL_W-1:0]    COL_LAST    = COL_W'(IMG_W - 1);
    localparam logic [URAM_A_W-1:0] URAM_STRIDE = URAM_A_W'(ADDR_STRIDE);

    line_buf_state_e     state;
    logic                pre_en;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [URAM_A_W-1:0] uram_addr_q;
    logic                init_q;
    logic                frame_q;
    logic                step_q;
    logic                e_line [NUM_LINES];
    logic [COL_W-1:0]    col_cnt [NUM_LINES];

    // Steps are qualified on entry so nothing from PRELOAD/DRAIN reaches
    // the pipe, and again on exit so steps still in flight when the frame
    // ends are discarded.
    en_delay_line #(.DEPTH(STEP_REG)) u_step_reg (
        .clk (clk),
        .rst (rst),
        .d   (step & (state == RUN)),
        .q   (step_q)
    );

    assign uram_rd_en   = pre_en | (step_q & (state == RUN));
    assign uram_rd_addr = uram_addr_q;
    assign init_done    = init_q;
    assign frame_done   = frame_q;

    // Frame FSM. beat_cnt spans the whole frame, preload beats included,
    // so RUN simply continues counting where PRELOAD stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pre_en      <= 1'b0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            uram_addr_q <= '0;
            init_q      <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= PRELOAD;
                        pre_en      <= 1'b1;
                        beat_cnt    <= '0;
                        uram_addr_q <= '0;
                    end
                end
                PRELOAD: begin
                    uram_addr_q <= uram_addr_q + URAM_STRIDE;
                    beat_cnt    <= beat_cnt + BEAT_W'(1);
                    if (beat_cnt == PRE_LAST) begin
                        pre_en    <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        init_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                RUN: begin
                    if (step_q) begin
                        if (beat_cnt == FRAME_LAST) begin
                            uram_addr_q <= '0;
                            beat_cnt    <= '0;
                            init_q      <= 1'b0;
                            frame_q     <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            uram_addr_q <= uram_addr_q + URAM_STRIDE;
                            beat_cnt    <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Enable cascade: keeps shifting in every state so beats already issued
    // always land in their buffers.
    en_delay_line #(.DEPTH(URAM_LAT)) u_uram_lat (
        .clk (clk),
        .rst (rst),
        .d   (uram_rd_en),
        .q   (e_line[0])
    );

    for (genvar i = 1; i < NUM_LINES; i++) begin : g_cascade
        en_delay_line #(.DEPTH(BRAM_LAT)) u_bram_lat (
            .clk (clk),
            .rst (rst),
            .d   (e_line[i-1]),
            .q   (e_line[i])
        );
    end

    // Per-buffer column counters, one step per enabled cycle of that buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) col_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (e_line[i]) begin
                    col_cnt[i] <= (col_cnt[i] == COL_LAST) ? '0 : col_cnt[i] + COL_W'(1);
                end
            end
        end
    end

    always_comb begin
        bram_en   = '0;
        bram_addr = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            bram_en[i] = e_line[i];
            bram_addr[i*BRAM_A_W +: BRAM_A_W] = BRAM_A_W'(32'(col_cnt[i]) * ADDR_STRIDE);
        end
    end

endmodule

// File: tb/tb_line_buf_addr_gen.sv
// tb_line_buf_addr_gen
//   Directed bench for line_buf_addr_gen. Cycle k's value of a signal is
//   the value present at posedge k (sampled on the preceding negedge).
//   Default instance: IMG_W=4, IMG_H=5, NUM_LINES=3, URAM_LAT=3, BRAM_LAT=2,
//   STEP_REG=1. Second instance: NUM_LINES=5, URAM_LAT=2, BRAM_LAT=3,
//   STEP_REG=3, IMG_H=8.
module tb_line_buf_addr_gen;

    localparam int NCYC = 61;
    localparam int BW   = 14;

    typedef enum int {SIG_UE, SIG_UA, SIG_BE0, SIG_BE1, SIG_BE2, SIG_ID, SIG_FD} sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start, step;
    logic start2, step2;

    logic [22:0]   ua;
    logic          ue;
    logic [3*BW-1:0] ba;
    logic [2:0]    be;
    logic          id, fd;

    logic [22:0]   ua2;
    logic          ue2;
    logic [5*BW-1:0] ba2;
    logic [4:0]    be2;
    logic          id2, fd2;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];
    int   step_cyc[$];

    logic          tr_ue [NCYC];
    logic [31:0]   tr_ua [NCYC];
    logic [2:0]    tr_be [NCYC];
    logic [3*BW-1:0] tr_ba [NCYC];
    logic          tr_id [NCYC];
    logic          tr_fd [NCYC];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    line_buf_addr_gen #(
        .IMG_W(4), .IMG_H(5), .NUM_LINES(3), .ADDR_STRIDE(16),
        .URAM_A_W(23), .BRAM_A_W(BW), .URAM_LAT(3), .BRAM_LAT(2), .STEP_REG(1)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .step(step),
        .uram_rd_addr(ua), .uram_rd_en(ue), .bram_addr(ba), .bram_en(be),
        .init_done(id), .frame_done(fd)
    );

    line_buf_addr_gen #(
        .IMG_W(4), .IMG_H(8), .NUM_LINES(5), .ADDR_STRIDE(16),
        .URAM_A_W(23), .BRAM_A_W(BW), .URAM_LAT(2), .BRAM_LAT(3), .STEP_REG(3)
    ) u_big (
        .clk(clk), .rst(rst), .start(start2), .step(step2),
        .uram_rd_addr(ua2), .uram_rd_en(ue2), .bram_addr(ba2), .bram_en(be2),
        .init_done(id2), .frame_done(fd2)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int cyc,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Hand-derived URAM beat windows for the default frame stimulus:
    // preload 1..12, steps at 30,31 -> 31,32, steps at 40..45 -> 41..46.
    function automatic logic exp_ue(input int c);
        return (c >= 1 && c <= 12) || c == 31 || c == 32 || (c >= 41 && c <= 46);
    endfunction

    function automatic logic [31:0] trace_val(input sig_e s, input int c);
        case (s)
            SIG_UE:  return 32'(tr_ue[c]);
            SIG_UA:  return tr_ua[c];
            SIG_BE0: return 32'(tr_be[c][0]);
            SIG_BE1: return 32'(tr_be[c][1]);
            SIG_BE2: return 32'(tr_be[c][2]);
            SIG_ID:  return 32'(tr_id[c]);
            SIG_FD:  return 32'(tr_fd[c]);
            default: return '0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_frame();
        int bi;
        int kb [3];
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            tr_ue[c] = ue;
            tr_ua[c] = 32'(ua);
            tr_be[c] = be;
            tr_ba[c] = ba;
            tr_id[c] = id;
            tr_fd[c] = fd;
            start = (c == 0);
            step  = 1'b0;
            foreach (step_cyc[j]) if (step_cyc[j] == c) step = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        step  = 1'b0;

        bi = 0;
        for (int i = 0; i < 3; i++) kb[i] = 0;
        for (int c = 0; c < NCYC; c++) begin
            check("uram_rd_en", c, 32'(tr_ue[c]), 32'(exp_ue(c)));
            if (exp_ue(c)) begin
                check("uram_rd_addr", c, tr_ua[c], 32'(bi * 16));
                bi++;
            end
            for (int i = 0; i < 3; i++) begin
                logic eb;
                eb = exp_ue(c - 3 - 2 * i);
                check($sformatf("bram_en%0d", i), c, 32'(tr_be[c][i]), 32'(eb));
                if (eb) begin
                    check($sformatf("bram_addr%0d", i), c,
                          32'(tr_ba[c][i*BW +: BW]), 32'((kb[i] % 4) * 16));
                    kb[i]++;
                end
            end
            check("init_done", c, 32'(tr_id[c]), 32'(c >= 20 && c <= 46));
            check("frame_done", c, 32'(tr_fd[c]), 32'(c == 47));
        end

        foreach (vecs[k])
            check(vecs[k].name, vecs[k].cyc, trace_val(vecs[k].sig, vecs[k].cyc), vecs[k].exp);
    endtask

    task automatic reset_mid_preload();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = (c == 0);
        end
        @(negedge clk);
        start = 1'b0;
        check("preload_active_c6", 6, 32'(ue), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_uram_rd_en", 6, 32'(ue), 32'd0);
        check("rst_uram_rd_addr", 6, 32'(ua), 32'd0);
        check("rst_bram_en", 6, 32'(be), 32'd0);
        check("rst_bram_addr", 6, 32'(ba[31:0]), 32'd0);
        check("rst_init_done", 6, 32'(id), 32'd0);
        check("rst_frame_done", 6, 32'(fd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("post_rst_uram_rd_en", c, 32'(ue), 32'd0);
            check("post_rst_bram_en", c, 32'(be), 32'd0);
        end
    endtask

    task automatic param_sweep();
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            check("big_init_done", c, 32'(id2), 32'(c >= 35));
            check("big_uram_rd_en", c, 32'(ue2), 32'((c >= 1 && c <= 20) || c == 43));
            check("big_bram_en0", c, 32'(be2[0]), 32'((c >= 3 && c <= 22) || c == 45));
            check("big_bram_en4", c, 32'(be2[4]), 32'(c == 57 || (c >= 15 && c <= 34)));
            start2 = (c == 0);
            step2  = (c == 40);
        end
        @(negedge clk);
        start2 = 1'b0;
        step2  = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        step   = 1'b0;
        start2 = 1'b0;
        step2  = 1'b0;

        step_cyc = '{0, 15, 30, 31, 40, 41, 42, 43, 44, 45};
        vecs.push_back('{1,  SIG_UA,  32'd0,   "preload_first_addr"});
        vecs.push_back('{12, SIG_UA,  32'd176, "preload_last_addr"});
        vecs.push_back('{13, SIG_UE,  32'd0,   "preload_end"});
        vecs.push_back('{3,  SIG_BE0, 32'd0,   "be0_before"});
        vecs.push_back('{4,  SIG_BE0, 32'd1,   "be0_first"});
        vecs.push_back('{15, SIG_BE0, 32'd1,   "be0_last"});
        vecs.push_back('{16, SIG_BE0, 32'd0,   "be0_after"});
        vecs.push_back('{8,  SIG_BE2, 32'd1,   "be2_first"});
        vecs.push_back('{19, SIG_BE2, 32'd1,   "be2_last"});
        vecs.push_back('{20, SIG_BE2, 32'd0,   "be2_after"});
        vecs.push_back('{19, SIG_ID,  32'd0,   "init_before"});
        vecs.push_back('{20, SIG_ID,  32'd1,   "init_rise"});
        vecs.push_back('{16, SIG_UE,  32'd0,   "step_in_drain_ignored"});
        vecs.push_back('{31, SIG_UA,  32'd192, "step0_addr"});
        vecs.push_back('{32, SIG_UA,  32'd208, "step1_addr"});
        vecs.push_back('{35, SIG_BE1, 32'd0,   "be1_step_before"});
        vecs.push_back('{36, SIG_BE1, 32'd1,   "be1_step0"});
        vecs.push_back('{37, SIG_BE1, 32'd1,   "be1_step1"});
        vecs.push_back('{38, SIG_BE1, 32'd0,   "be1_step_after"});
        vecs.push_back('{47, SIG_FD,  32'd1,   "frame_done_pulse"});
        vecs.push_back('{48, SIG_FD,  32'd0,   "frame_done_once"});
        vecs.push_back('{47, SIG_ID,  32'd0,   "init_drop"});
        vecs.push_back('{47, SIG_UA,  32'd0,   "uram_addr_wrap"});

        repeat (3) @(negedge clk);
        check("reset_uram_rd_en", 0, 32'(ue), 32'd0);
        check("reset_uram_rd_addr", 0, 32'(ua), 32'd0);
        check("reset_bram_en", 0, 32'(be), 32'd0);
        check("reset_init_done", 0, 32'(id), 32'd0);
        check("reset_frame_done", 0, 32'(fd), 32'd0);
        check("reset_big_bram_en", 0, 32'(be2), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame();
        run_frame();
        reset_mid_preload();
        param_sweep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
